// File: rtl/fp_seq_pkg.sv
// Shared types and word-format constants for the tinyZuse floating-point sequencers.
package fp_seq_pkg;

    localparam int EXP_W   = 7;
    localparam int MANT_W  = 16;
    localparam int WORD_W  = 24;
    localparam int EXP_MAX = 63;
    localparam int EXP_MIN = -64;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXP,
        S_ALIGN,
        S_ADD,
        S_NORM,
        S_DONE
    } fp_state_t;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-1:0] mant;
    } fp_word_t;

    // A zero operand gets the smallest exponent so it always loses the magnitude compare.
    function automatic fp_word_t canon(input fp_word_t w);
        fp_word_t r;
        r = w;
        if (w.mant == '0) r.exp = EXP_MIN[EXP_W-1:0];
        return r;
    endfunction

endpackage

// File: rtl/fp_addsub_seq_if.sv
// Operand/result handshake between the instruction front end and a floating-point sequencer.
interface fp_addsub_seq_if;
    import fp_seq_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic              op;
    logic [WORD_W-1:0] opa;
    logic [WORD_W-1:0] opb;
    logic              out_valid;
    logic [WORD_W-1:0] result;
    logic              ovf;
    logic              unf;

    modport master (output in_valid, op, opa, opb,
                    input  in_ready, out_valid, result, ovf, unf);
    modport slave  (input  in_valid, op, opa, opb,
                    output in_ready, out_valid, result, ovf, unf);
endinterface

// File: rtl/fp_addsub_seq_dp.sv
// Shared datapath units: exponent adder, mantissa barrel shifter, mantissa adder.
module alu_a
    import fp_seq_pkg::*;
(
    input  logic [EXP_W-1:0] a_i,
    input  logic [EXP_W-1:0] b_i,
    output logic [EXP_W:0]   diff_o
);
    assign diff_o = {a_i[EXP_W-1], a_i} + ~{b_i[EXP_W-1], b_i} + {{EXP_W{1'b0}}, 1'b1};
endmodule

module bb_shifter
    import fp_seq_pkg::*;
(
    input  logic [MANT_W-1:0] din_i,
    input  logic [EXP_W:0]    shamt_i,
    output logic [MANT_W-1:0] dout_o
);
    localparam int SH_W = $clog2(MANT_W);

    assign dout_o = (shamt_i >= (EXP_W+1)'(MANT_W)) ? '0 : din_i >> shamt_i[SH_W-1:0];
endmodule

module alu_b
    import fp_seq_pkg::*;
(
    input  logic [MANT_W-1:0] a_i,
    input  logic [MANT_W-1:0] b_i,
    input  logic              sub_i,
    output logic [MANT_W:0]   sum_o
);
    // B is widened before inversion so a difference lands in 17 bits without a stray carry.
    assign sum_o = {1'b0, a_i} + (sub_i ? ~{1'b0, b_i} : {1'b0, b_i}) + {{MANT_W{1'b0}}, sub_i};
endmodule

// File: rtl/fp_addsub_seq.sv
// One floating-point add/subtract sequenced over alu_a, bb_shifter and alu_b: compare, align, add, normalize.
module fp_addsub_seq
    import fp_seq_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    fp_addsub_seq_if.slave bus
);
    localparam logic signed [EXP_W:0] WEXP_MAX = EXP_MAX[EXP_W:0];
    localparam logic signed [EXP_W:0] WEXP_MIN = EXP_MIN[EXP_W:0];
    localparam logic signed [EXP_W:0] WEXP_ONE = (EXP_W+1)'(1);

    fp_state_t                state_q, state_d;
    logic                     sa_q, sa_d, sb_q, sb_d;
    logic [EXP_W-1:0]         ea_q, ea_d, eb_q, eb_d;
    logic [MANT_W-1:0]        ma_q, ma_d, mb_q, mb_d;
    logic [EXP_W:0]           d_q, d_d;
    logic [MANT_W:0]          m_q, m_d;
    logic signed [EXP_W:0]    we_q, we_d;
    logic [WORD_W-1:0]        res_q, res_d;
    logic                     ovf_q, ovf_d, unf_q, unf_d;

    fp_word_t                 opa_w, opb_w;
    logic [EXP_W:0]           ediff;
    logic [MANT_W-1:0]        mb_sh;
    logic [MANT_W:0]          msum;
    logic signed [EXP_W:0]    we_inc, we_dec;
    logic                     swap;

    alu_a      u_alu_a (.a_i(ea_q), .b_i(eb_q), .diff_o(ediff));
    bb_shifter u_shift (.din_i(mb_q), .shamt_i(d_q), .dout_o(mb_sh));
    alu_b      u_alu_b (.a_i(ma_q), .b_i(mb_q), .sub_i(sa_q ^ sb_q), .sum_o(msum));

    assign opa_w  = canon(bus.opa);
    assign opb_w  = canon(bus.opb);
    // A stays the larger magnitude; equal magnitudes keep the original order.
    assign swap   = ediff[EXP_W] || ((ediff == '0) && (mb_q > ma_q));
    assign we_inc = we_q + WEXP_ONE;
    assign we_dec = we_q - WEXP_ONE;

    always_comb begin
        state_d = state_q;
        sa_d  = sa_q;  sb_d  = sb_q;
        ea_d  = ea_q;  eb_d  = eb_q;
        ma_d  = ma_q;  mb_d  = mb_q;
        d_d   = d_q;   m_d   = m_q;   we_d = we_q;
        res_d = res_q; ovf_d = ovf_q; unf_d = unf_q;
        unique case (state_q)
            S_IDLE: if (bus.in_valid) begin
                sa_d = opa_w.sign;           ea_d = opa_w.exp; ma_d = opa_w.mant;
                sb_d = opb_w.sign ^ bus.op;  eb_d = opb_w.exp; mb_d = opb_w.mant;
                state_d = S_EXP;
            end
            S_EXP: begin
                if (swap) begin
                    sa_d = sb_q; ea_d = eb_q; ma_d = mb_q;
                    sb_d = sa_q; eb_d = ea_q; mb_d = ma_q;
                end
                d_d = ediff[EXP_W] ? (~ediff + (EXP_W+1)'(1)) : ediff;
                state_d = S_ALIGN;
            end
            S_ALIGN: begin
                mb_d    = mb_sh;
                state_d = S_ADD;
            end
            S_ADD: begin
                m_d     = msum;
                we_d    = {ea_q[EXP_W-1], ea_q};
                state_d = S_NORM;
            end
            S_NORM: begin
                if (m_q == '0) begin
                    res_d = '0; ovf_d = 1'b0; unf_d = 1'b0;
                    state_d = S_DONE;
                end else if (m_q[MANT_W]) begin
                    unf_d = 1'b0;
                    if (we_inc > WEXP_MAX) begin
                        ovf_d = 1'b1;
                        res_d = {sa_q, EXP_MAX[EXP_W-1:0], {MANT_W{1'b1}}};
                    end else begin
                        ovf_d = 1'b0;
                        res_d = {sa_q, we_inc[EXP_W-1:0], m_q[MANT_W:1]};
                    end
                    state_d = S_DONE;
                end else if (m_q[MANT_W-1]) begin
                    res_d = {sa_q, we_q[EXP_W-1:0], m_q[MANT_W-1:0]};
                    ovf_d = 1'b0; unf_d = 1'b0;
                    state_d = S_DONE;
                end else if (we_dec < WEXP_MIN) begin
                    res_d = '0; ovf_d = 1'b0; unf_d = 1'b1;
                    state_d = S_DONE;
                end else begin
                    m_d  = {m_q[MANT_W-1:0], 1'b0};
                    we_d = we_dec;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            sa_q  <= 1'b0; sb_q  <= 1'b0;
            ea_q  <= '0;   eb_q  <= '0;
            ma_q  <= '0;   mb_q  <= '0;
            d_q   <= '0;   m_q   <= '0;   we_q <= '0;
            res_q <= '0;   ovf_q <= 1'b0; unf_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q  <= sa_d;  sb_q  <= sb_d;
            ea_q  <= ea_d;  eb_q  <= eb_d;
            ma_q  <= ma_d;  mb_q  <= mb_d;
            d_q   <= d_d;   m_q   <= m_d;   we_q <= we_d;
            res_q <= res_d; ovf_q <= ovf_d; unf_q <= unf_d;
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.result    = res_q;
    assign bus.ovf       = ovf_q;
    assign bus.unf       = unf_q;

endmodule

// File: tb/tb_fp_addsub_seq.sv
// Scoreboard bench for fp_addsub_seq: directed cases, handshake/reset cases and random ops against a value-level model.
module tb_fp_addsub_seq;
    import fp_seq_pkg::*;

    typedef struct {
        logic [23:0] res;
        logic        ovf;
        logic        unf;
        int          lat;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    int   nresp = 0;
    exp_t expq[$];
    exp_t mon_e;

    fp_addsub_seq_if bus ();
    fp_addsub_seq dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic exp_t mk(input logic [23:0] r, input logic ov, input logic un, input int lat);
        exp_t x;
        x.res = r; x.ovf = ov; x.unf = un; x.lat = lat; x.acc = 0;
        return x;
    endfunction

    // Value-level reference: pick the larger magnitude, align, add, then normalise by leading-one position.
    function automatic exp_t model(input logic [23:0] a, input logic [23:0] b, input logic o);
        exp_t x;
        int ea, eb, ma, mb, t, d, m, e, k;
        logic sa, sb, ts;
        sa = a[23]; sb = b[23] ^ o;
        ma = int'(a[15:0]); mb = int'(b[15:0]);
        ea = int'(a[22:16]); if (ea > 63) ea -= 128; if (ma == 0) ea = -64;
        eb = int'(b[22:16]); if (eb > 63) eb -= 128; if (mb == 0) eb = -64;
        if (eb > ea || (eb == ea && mb > ma)) begin
            t = ea; ea = eb; eb = t;
            t = ma; ma = mb; mb = t;
            ts = sa; sa = sb; sb = ts;
        end
        d  = ea - eb;
        mb = (d >= 16) ? 0 : (mb >> d);
        m  = (sa == sb) ? ma + mb : ma - mb;
        e  = ea;
        x = mk(24'h0, 1'b0, 1'b0, 4);
        if (m == 0) begin
            x.res = 24'h0;
        end else if (m > 65535) begin
            m = m / 2; e = e + 1;
            if (e > 63) begin x.ovf = 1'b1; x.res = {sa, 7'h3F, 16'hFFFF}; end
            else x.res = {sa, 7'(e), 16'(m)};
        end else begin
            k = 0;
            while (m < 32768) begin m = m * 2; k++; end
            if (e - k < -64) begin x.unf = 1'b1; x.res = 24'h0; x.lat = 4 + (e + 64); end
            else begin x.res = {sa, 7'(e - k), 16'(m)}; x.lat = 4 + k; end
        end
        return x;
    endfunction

    function automatic logic [23:0] rnd_op(input logic [6:0] e_near);
        logic [6:0]  e;
        logic [15:0] m;
        case ($urandom_range(0, 5))
            0:       e = 7'h3F;
            1:       e = 7'h40;
            2, 3:    e = e_near + 7'($urandom_range(0, 6)) - 7'd3;
            default: e = 7'($urandom);
        endcase
        m = ($urandom_range(0, 9) == 0) ? 16'h0 : {1'b1, 15'($urandom)};
        return {1'($urandom), e, m};
    endfunction

    task automatic send(input logic [23:0] a, input logic [23:0] b, input logic o, input exp_t e);
        int g;
        g = 0;
        @(negedge clk);
        while (!bus.in_ready && g < 100) begin @(negedge clk); g++; end
        check("in_ready_wait", bus.in_ready, 1'b1);
        bus.in_valid = 1'b1; bus.opa = a; bus.opb = b; bus.op = o;
        e.acc = cyc + 1;
        expq.push_back(e);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while ((expq.size() != 0 || !bus.in_ready) && g < 200) begin @(negedge clk); g++; end
        check("drain_pending", expq.size(), 0);
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.out_valid) begin
            nresp++;
            if (expq.size() == 0) begin
                tests++; fails++;
                $display("FAIL spurious_out_valid: got result %h, expected no response", bus.result);
            end else begin
                mon_e = expq.pop_front();
                check("result",  bus.result, mon_e.res);
                check("ovf",     bus.ovf,    mon_e.ovf);
                check("unf",     bus.unf,    mon_e.unf);
                check("latency", cyc - mon_e.acc, mon_e.lat);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] a, b;
        logic        o;
        logic        seen;
        int          r0;
        bus.in_valid = 1'b0; bus.op = 1'b0; bus.opa = '0; bus.opb = '0;
        repeat (2) @(negedge clk);
        check("rst_in_ready",  bus.in_ready,  1'b1);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_result",    bus.result,    24'h0);
        check("rst_ovf",       bus.ovf,       1'b0);
        check("rst_unf",       bus.unf,       1'b0);
        rst_n = 1'b1;

        send(24'h008000, 24'h008000, 1'b0, mk(24'h018000, 1'b0, 1'b0, 4));
        send(24'h00C000, 24'h008000, 1'b1, mk(24'h7F8000, 1'b0, 1'b0, 5));
        send(24'h008000, 24'h008000, 1'b1, mk(24'h000000, 1'b0, 1'b0, 4));
        send(24'h008000, 24'h6C8000, 1'b0, mk(24'h008000, 1'b0, 1'b0, 4));
        send(24'h6C8000, 24'h008000, 1'b0, mk(24'h008000, 1'b0, 1'b0, 4));
        send(24'h3F8000, 24'h3F8000, 1'b0, mk(24'h3FFFFF, 1'b1, 1'b0, 4));
        send(24'h40C000, 24'h408000, 1'b1, mk(24'h000000, 1'b0, 1'b1, 4));
        send(24'h008001, 24'h008000, 1'b1, mk(24'h718000, 1'b0, 1'b0, 19));
        send(24'h000000, 24'h7F8000, 1'b0, mk(24'h7F8000, 1'b0, 1'b0, 4));
        send(24'h808000, 24'h008000, 1'b0, mk(24'h000000, 1'b0, 1'b0, 4));
        send(24'h808000, 24'h008000, 1'b1, mk(24'h818000, 1'b0, 1'b0, 4));
        drain();

        // in_valid held high for a whole operation with operands changing while busy
        @(negedge clk);
        bus.in_valid = 1'b1; bus.opa = 24'h00C000; bus.opb = 24'h008000; bus.op = 1'b1;
        mon_e = mk(24'h7F8000, 1'b0, 1'b0, 5);
        mon_e.acc = cyc + 1;
        expq.push_back(mon_e);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk); #1;
            bus.opa = 24'($urandom); bus.opb = 24'($urandom); bus.op = 1'($urandom);
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
            else check("busy_in_ready", bus.in_ready, 1'b0);
        end
        bus.in_valid = 1'b0;
        check("hold_out_valid_seen", seen, 1'b1);
        @(negedge clk);
        check("ready_after_done", bus.in_ready, 1'b1);
        drain();

        // reset in NORM abandons the op and clears the held result
        send(24'h3F8000, 24'h3F8000, 1'b0, mk(24'h3FFFFF, 1'b1, 1'b0, 4));
        drain();
        @(negedge clk);
        bus.in_valid = 1'b1; bus.opa = 24'h008001; bus.opb = 24'h008000; bus.op = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_result",    bus.result,    24'h0);
        check("abort_ovf",       bus.ovf,       1'b0);
        check("abort_unf",       bus.unf,       1'b0);
        check("abort_out_valid", bus.out_valid, 1'b0);
        check("abort_in_ready",  bus.in_ready,  1'b1);
        expq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        r0 = nresp;
        repeat (25) @(negedge clk);
        check("abort_no_response", nresp - r0, 0);
        send(24'h008000, 24'h008000, 1'b0, mk(24'h018000, 1'b0, 1'b0, 4));
        drain();

        for (int i = 0; i < 150; i++) begin
            a = rnd_op(7'($urandom));
            b = ($urandom_range(0, 7) == 0) ? {1'($urandom), a[22:0]} : rnd_op(a[22:16]);
            o = 1'($urandom);
            send(a, b, o, model(a, b, o));
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fp_addsub_seq.md
# fp_addsub_seq

Sequencer for one floating-point add/subtract on the shared tinyZuse arithmetic datapath. It accepts two packed operands and an operation bit, then steps the exponent adder (`alu_a`), mantissa shifter (`bb_shifter`) and mantissa adder (`alu_b`) through compare, align, add and normalize. It returns one packed result with overflow and underflow flags. It sits between the instruction/IO front end and the datapath and handles one operation at a time.

## Interface
Parameters: none. Widths are fixed by the package.

Operand and result word format (24 bits):
- [23] sign.
- [22:16] exponent, 7-bit two's complement, range −64..63.
- [15:0] mantissa with an explicit leading one at bit 15. Value = m/2^15 · 2^e.
- Zero has mantissa 0; sign and exponent are ignored on input.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset. This choice is fixed.
- `in_valid` in 1: the operands and `op` are valid this cycle.
- `in_ready` out 1: high only in IDLE.
- `op` in 1: 0 = opa + opb, 1 = opa − opb.
- `opa`, `opb` in 24: operands, sampled on the accepting edge.
- `out_valid` out 1: one-cycle pulse when the result is ready.
- `result` out 24: registered result, held until the next `out_valid`.
- `ovf` out 1: overflow flag, valid with `out_valid` and held with `result`.
- `unf` out 1: underflow flag, valid with `out_valid` and held with `result`.

## Operation
States are IDLE → EXP → ALIGN → ADD → NORM (repeats) → DONE → IDLE.

- **Accept:** a transfer happens when `in_valid && in_ready`. In all other states `in_valid` is ignored.
- **Operand registers:** registered operands with mantissa 0 become {exp = −64, mant = 0}.
- **Effective sign:** sb' = sb ^ op.
- **EXP:**
  - alu_a computes ea + ~eb + 1, sign-extended to 8 bits.
  - Swap so that A is the larger magnitude: larger exponent first, mantissa compare if exponents are equal, keep A on a tie.
  - Store d = |ea − eb|.
- **ALIGN:** mantissa B is shifted right by min(d, 16). Shifted-out bits are truncated; d ≥ 16 gives 0.
- **ADD:**
  - If sa == sb': 17-bit sum mA + mB; the result sign is sa.
  - Otherwise: mA − mB, computed as mA + ~mB + 1 and taken to 17 bits. It is never negative; the result sign is the sign of A.
  - The working exponent is 8 bits wide and equals eA.
- **NORM** (one check per cycle, first matching rule):
  1. m == 0 → result is 0x000000 (sign 0); go to DONE.
  2. m[16] == 1 → shift m right 1 (LSB dropped), exp + 1; go to DONE.
  3. m[15] == 1 → go to DONE.
  4. Otherwise shift m left 1, exp − 1, and stay in NORM.
- **Overflow:** if the exponent exceeds 63 after rule 2, set `ovf` and saturate the result to {sign, 63, 0xFFFF}.
- **Underflow:** if rule 4 would take the exponent below −64, set `unf`, make the result 0x000000, and go to DONE.
- **DONE:**
  - `result`, `ovf` and `unf` are loaded.
  - `out_valid` is 1 for this cycle only.
  - The next state is IDLE.
- There is no rounding: every shift truncates.

## Timing
- **Reset (async, any state):**
  - State goes to IDLE.
  - `in_ready` = 1, `out_valid` = 0, `result` = 0, `ovf` = 0, `unf` = 0.
  - An operation in flight is abandoned and produces no `out_valid`.
- **Latency:** let accept be edge E0, and let k be the number of NORM left shifts.
  - The state is EXP after E0, ALIGN after E1, ADD after E2 and NORM after E3.
  - `out_valid` is high after edge E4+k. Latency is 4+k cycles, with k ≤ 15.
- **Back-to-back:** the next accept can happen at the earliest on the edge that leaves DONE. `in_ready` rises in the cycle after `out_valid`.
- **Stability:** `in_ready` is 0 from E0 until the state returns to IDLE. The operands do not need to stay stable after E0.

## Structure
- Package `fp_seq_pkg`, shared with future multiply/divide sequencers, holds:
  - the state enum `fp_state_t`;
  - `EXP_W` = 7, `MANT_W` = 16, `WORD_W` = 24;
  - `EXP_MAX` = 63, `EXP_MIN` = −64.
- `fp_addsub_seq` contains the FSM and the operand, working and result registers. It instantiates `alu_a`, `bb_shifter` and `alu_b` directly.
- The NORM rules and the swap compare are inline logic. No further sub-module is needed.

## Test plan
- 0x008000 + 0x008000, op = 0 (1.0 + 1.0) → result 0x018000, `ovf` = `unf` = 0, `out_valid` 4 cycles after accept.
- 0x00C000 − 0x008000 (1.5 − 1.0) → result 0x7F8000 (0.5), latency 5. Also check 0x008000 − 0x008000 → 0x000000, latency 4.
- 0x008000 + 0x6C8000 (1.0 + 2^−20, d = 20) → result 0x008000. Swapped operand order gives the same result.
- 0x3F8000 + 0x3F8000 → `ovf` = 1, result 0x3FFFFF.
- 0x40C000 − 0x408000 → `unf` = 1, result 0x000000.
- Handshake and reset:
  - Hold `in_valid` high through a whole operation: exactly one accept, and the operands presented while busy are ignored.
  - Pull `rst_n` low during NORM: outputs are 0 immediately, there is no `out_valid`, and a fresh operation afterwards completes normally.
